// File: rtl/pipe_buf_pkg.sv
// Shared types for the inter-stage pipeline buffer (pipe_stage_buf).
// Holds the occupancy state encoding and the occupancy counter width.
package pipe_buf_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } pipe_buf_state_t;

   localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/pipe_buf_reg.sv
// Single valid+data register slice with load, flush and reset value.
// Used for the main and skid entries of pipe_stage_buf.
module pipe_buf_reg
   import pipe_buf_pkg::*;
#(
   parameter int unsigned    W         = 32,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic         flush,
   input  logic         load,
   input  logic         valid_d,
   input  logic [W-1:0] data_d,
   output logic         valid,
   output logic [W-1:0] data
);

   // Data only changes when a live beat lands; draining keeps the last payload.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (load) begin
         valid <= valid_d;
         if (valid_d) begin
            data <= data_d;
         end
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, optional 2-entry skid,
// flush and legacy stall. Define PIPE_TRACE_EN to add the tracer sideband.
module pipe_stage_buf
   import pipe_buf_pkg::*;
#(
   parameter int unsigned         DATA_W     = 32,
   parameter bit                  SKID_EN    = 1'b1,
   parameter logic [DATA_W-1:0]   RESET_DATA = '0
`ifdef PIPE_TRACE_EN
   ,
   parameter int unsigned         TRACE_W    = 64
`endif
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              stall_en,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_TRACE_EN
   input  logic [TRACE_W-1:0] in_trace,
   output logic [TRACE_W-1:0] out_trace,
`endif
   output logic [OCC_W-1:0]  occupancy
);

   logic              main_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic [DATA_W-1:0] main_d;

   logic              acc;
   logic              rel;
   logic              main_load;
   logic              main_vd;
   logic              main_sel_skid;
   logic              skid_load;
   logic              skid_vd;

   pipe_buf_state_t   state;

   assign acc = in_valid & in_ready & ~stall_en;
   assign rel = out_valid & out_ready & ~stall_en;

   always_comb begin
      if (skid_valid) begin
         state = TWO;
      end else if (main_valid) begin
         state = ONE;
      end else begin
         state = EMPTY;
      end
   end

   // Stall needs no explicit branch: it already masks acc and rel.
   always_comb begin
      main_load     = 1'b0;
      main_vd       = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_vd       = 1'b0;
      unique case (state)
         EMPTY: begin
            if (acc) begin
               main_load = 1'b1;
               main_vd   = 1'b1;
            end
         end
         ONE: begin
            if (acc && rel) begin
               main_load = 1'b1;
               main_vd   = 1'b1;
            end else if (acc) begin
               skid_load = 1'b1;
               skid_vd   = 1'b1;
            end else if (rel) begin
               main_load = 1'b1;
               main_vd   = 1'b0;
            end
         end
         TWO: begin
            if (rel) begin
               main_load     = 1'b1;
               main_vd       = 1'b1;
               main_sel_skid = 1'b1;
               skid_load     = 1'b1;
               skid_vd       = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign main_d = main_sel_skid ? skid_data : in_data;

   pipe_buf_reg #(
      .W         (DATA_W),
      .RESET_VAL (RESET_DATA)
   ) u_main (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .flush   (flush),
      .load    (main_load),
      .valid_d (main_vd),
      .data_d  (main_d),
      .valid   (main_valid),
      .data    (main_data)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_buf_reg #(
            .W         (DATA_W),
            .RESET_VAL (RESET_DATA)
         ) u_skid (
            .ACLK    (ACLK),
            .ARESET  (ARESET),
            .flush   (flush),
            .load    (skid_load),
            .valid_d (skid_vd),
            .data_d  (in_data),
            .valid   (skid_valid),
            .data    (skid_data)
         );
         assign in_ready = ~skid_valid & ~stall_en & ~ARESET;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_data  = RESET_DATA;
         assign in_ready   = ~main_valid | out_ready;
      end
   endgenerate

`ifdef PIPE_TRACE_EN
   logic [TRACE_W-1:0] main_trace;
   logic [TRACE_W-1:0] skid_trace;
   logic [TRACE_W-1:0] main_trace_d;
   logic               main_trace_v;
   logic               skid_trace_v;

   // Sideband slices share every control with the payload slices.
   assign main_trace_d = main_sel_skid ? skid_trace : in_trace;

   pipe_buf_reg #(
      .W         (TRACE_W),
      .RESET_VAL ('0)
   ) u_main_trace (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .flush   (flush),
      .load    (main_load),
      .valid_d (main_vd),
      .data_d  (main_trace_d),
      .valid   (main_trace_v),
      .data    (main_trace)
   );

   generate
      if (SKID_EN) begin : g_skid_trace
         pipe_buf_reg #(
            .W         (TRACE_W),
            .RESET_VAL ('0)
         ) u_skid_trace (
            .ACLK    (ACLK),
            .ARESET  (ARESET),
            .flush   (flush),
            .load    (skid_load),
            .valid_d (skid_vd),
            .data_d  (in_trace),
            .valid   (skid_trace_v),
            .data    (skid_trace)
         );
      end else begin : g_noskid_trace
         assign skid_trace_v = 1'b0;
         assign skid_trace   = '0;
      end
   endgenerate

   assign out_trace = main_trace;
`endif

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign occupancy = OCC_W'({1'b0, main_valid}) + OCC_W'({1'b0, skid_valid});

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DATA_W=32, skid enabled).
// Trace sideband checks are active when PIPE_TRACE_EN is defined.
module tb_pipe_stage_buf;

   localparam logic [31:0] RST_D = 32'h0BAD_F00D;

   logic        ACLK;
   logic        ARESET;
   logic        stall_en;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
`ifdef PIPE_TRACE_EN
   logic [63:0] in_trace;
   logic [63:0] out_trace;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage_buf #(
      .DATA_W     (32),
      .SKID_EN    (1'b1),
      .RESET_DATA (RST_D)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .stall_en  (stall_en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef PIPE_TRACE_EN
      .in_trace  (in_trace),
      .out_trace (out_trace),
`endif
      .occupancy (occupancy)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                          input logic [1:0] eocc);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(eocc));
      if (ev) begin
         chk({tag, ".out_data"}, 64'(out_data), 64'(ed));
`ifdef PIPE_TRACE_EN
         chk({tag, ".out_trace"}, out_trace, 64'(ed));
`endif
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      in_valid = v;
      in_data  = d;
`ifdef PIPE_TRACE_EN
      in_trace = 64'(d);
`endif
   endtask

   task automatic tick();
      @(negedge ACLK);
   endtask

   initial begin
      ARESET    = 1'b0;
      stall_en  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0);
      #2 ARESET = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst.in_ready", 64'(in_ready), 64'(0));
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      chk("rst.occupancy", 64'(occupancy), 64'(0));
      chk("rst.out_data", 64'(out_data), 64'(RST_D));
`ifdef PIPE_TRACE_EN
      chk("rst.out_trace", out_trace, 64'(0));
`endif
      ARESET = 1'b0;
      tick();
      chk("post_rst.in_ready", 64'(in_ready), 64'(1));

      // 1. Streaming 0x1..0x8
      out_ready = 1'b1;
      for (int unsigned i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i));
         tick();
         chk_out($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1);
         chk($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'(1));
      end
      drive(1'b0, 32'h0);
      tick();
      chk_out("stream_drain", 1'b0, 32'h0, 2'd0);

      // 2. Backpressure into skid
      drive(1'b1, 32'hA);
      tick();
      chk_out("bp_a", 1'b1, 32'hA, 2'd1);
      out_ready = 1'b0;
      drive(1'b1, 32'hB);
      tick();
      chk_out("bp_two", 1'b1, 32'hA, 2'd2);
      chk("bp_two.in_ready", 64'(in_ready), 64'(0));
      drive(1'b1, 32'hFF);
      out_ready = 1'b1;
      tick();
      chk_out("bp_b", 1'b1, 32'hB, 2'd1);
      drive(1'b0, 32'h0);
      tick();
      chk_out("bp_drain", 1'b0, 32'h0, 2'd0);

      // 3. Flush from TWO with 0xE offered
      out_ready = 1'b0;
      drive(1'b1, 32'hC);
      tick();
      drive(1'b1, 32'hD);
      tick();
      chk_out("fl_two", 1'b1, 32'hC, 2'd2);
      drive(1'b1, 32'hE);
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      chk_out("fl_empty", 1'b0, 32'h0, 2'd0);
      chk("fl.out_data", 64'(out_data), 64'(RST_D));
`ifdef PIPE_TRACE_EN
      chk("fl.out_trace", out_trace, 64'(0));
`endif
      tick();
      chk_out("fl_no_e", 1'b0, 32'h0, 2'd0);

      // 4. Stall in ONE
      drive(1'b1, 32'h10);
      tick();
      chk_out("st_one", 1'b1, 32'h10, 2'd1);
      drive(1'b1, 32'h11);
      stall_en = 1'b1;
      #1;
      chk("st.in_ready", 64'(in_ready), 64'(0));
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("st_hold%0d", i), 1'b1, 32'h10, 2'd1);
      end
      stall_en = 1'b0;
      tick();
      chk_out("st_resume", 1'b1, 32'h11, 2'd1);
      drive(1'b0, 32'h0);
      tick();
      chk_out("st_drain", 1'b0, 32'h0, 2'd0);

      // flush together with stall: flush wins
      out_ready = 1'b0;
      drive(1'b1, 32'h20);
      tick();
      drive(1'b0, 32'h0);
      stall_en = 1'b1;
      flush    = 1'b1;
      tick();
      stall_en = 1'b0;
      flush    = 1'b0;
      chk_out("fl_st", 1'b0, 32'h0, 2'd0);

      // 5. Async reset in TWO
      drive(1'b1, 32'h30);
      tick();
      drive(1'b1, 32'h31);
      tick();
      chk_out("ar_two", 1'b1, 32'h30, 2'd2);
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      #2 ARESET = 1'b1;
      #1;
      chk("ar.out_valid", 64'(out_valid), 64'(0));
      chk("ar.occupancy", 64'(occupancy), 64'(0));
      chk("ar.in_ready", 64'(in_ready), 64'(0));
      chk("ar.out_data", 64'(out_data), 64'(RST_D));
      tick();
      ARESET = 1'b0;
      tick();
      chk("ar_rel.in_ready", 64'(in_ready), 64'(1));
      chk_out("ar_no_emit", 1'b0, 32'h0, 2'd0);
      drive(1'b1, 32'h40);
      tick();
      chk_out("ar_flow", 1'b1, 32'h40, 2'd1);
      drive(1'b0, 32'h0);
      tick();
      chk_out("ar_drain", 1'b0, 32'h0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W payload between stages with a valid/ready handshake and a 2-entry skid buffer, so in_ready is registered and full throughput is kept.
- Adds a flush that inserts bubbles, and a legacy stall input for stages not yet on the handshake.
- One instance per stage boundary; the payload is the packed stage bus struct.

Parameters:
- DATA_W, 32: payload width in bits; the stage bus struct width is passed here.
- SKID_EN, 1: 1 = 2-entry skid buffer, registered in_ready; 0 = single register, in_ready = !out_valid | out_ready (combinational).
- RESET_DATA, '0: payload register value after reset and after flush.
- TRACE_W, 64: width of the tracer sideband; used only when PIPE_TRACE_EN is defined.

Ports:
- ACLK  in  1  clock; all state changes on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- stall_en  in  1  hold: blocks both accept and release this cycle.
- flush  in  1  discard all held and incoming beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to the next stage.
- occupancy  out  2  beats held: 0, 1 or 2.
- in_trace  in  TRACE_W  tracer sideband in (PIPE_TRACE_EN only).
- out_trace  out  TRACE_W  tracer sideband out (PIPE_TRACE_EN only).

Behaviour:
- Reset (ARESET=1, asynchronous):
  - main_valid=0, skid_valid=0, out_valid=0, occupancy=0.
  - out_data=RESET_DATA, skid data=RESET_DATA.
  - in_ready=0 while ARESET is high; in_ready=1 from the first edge after release.
- Handshake qualifiers:
  - acc = in_valid & in_ready & !stall_en.
  - rel = out_valid & out_ready & !stall_en.
- Ready and output generation:
  - SKID_EN=1: in_ready = !skid_valid & !stall_en & !ARESET, where skid_valid is a register.
  - out_valid = main_valid; out_data = main register. No combinational path from in_data to out_data.
- State machine (SKID_EN=1). EMPTY = no valid, ONE = main only, TWO = main + skid:
  - EMPTY: acc -> ONE, and main loads in_data.
  - ONE, acc & rel -> ONE: main reloads.
  - ONE, acc & !rel -> TWO: skid loads in_data.
  - ONE, !acc & rel -> EMPTY.
  - TWO, rel -> ONE: main takes skid. in_ready is 0 in TWO, so acc cannot occur.
  - TWO, !rel -> hold.
- Latency and throughput:
  - 1 cycle in_data -> out_data.
  - Sustained 1 beat per cycle with out_ready held high.
  - Order is strictly FIFO, with no duplication or loss except on flush.
- Flush:
  - Highest priority over acc and rel; next state is EMPTY.
  - Data registers are set to RESET_DATA.
  - A beat offered in the flush cycle is dropped.
  - rel in the flush cycle still counts as transferred downstream.
- stall_en:
  - Freezes all state; in_ready=0 for the cycle.
  - out_valid and out_data are held stable.
- Simultaneous events:
  - flush & stall_en together -> flush wins.
  - Reset asserted mid-transfer -> state returns to EMPTY immediately; no beat is emitted.
- occupancy = main_valid + skid_valid.
- SKID_EN=0: states are EMPTY and ONE only; skid_valid is tied 0.

Optional Feature:
- Macro: PIPE_TRACE_EN.
- Defined:
  - in_trace and out_trace ports exist.
  - The trace sideband is stored in parallel main and skid registers with identical load, hold and flush timing.
  - Reset and flush value of the sideband is '0.
- Undefined:
  - The ports and registers are absent.
  - Payload behaviour is identical.

Decomposition:
- Package pipe_buf_pkg holds:
  - enum pipe_buf_state_t {EMPTY, ONE, TWO};
  - OCC_W = 2.
- The stage bus struct typedefs stay in the existing CPU buffer bus package; the tracer bus type stays in the tracer package.
- One sub-module, pipe_buf_reg: a single valid+data register slice with load, flush and reset value.
  - Instantiated twice: main slice and skid slice.
  - The trace sideband uses a second instance per slice under PIPE_TRACE_EN.

Test Plan:
1. Streaming: DATA_W=32. Drive 0x1..0x8 back-to-back with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance; occupancy stays 1.
2. Backpressure: out_ready=0 after beat 0xA -> accept 0xB into skid; occupancy=2, in_ready=0 next cycle. Raise out_ready -> 0xA, 0xB released in order, with no loss and no duplicate.
3. Flush: hold 0xC and 0xD (TWO), then pulse flush together with in_valid of 0xE -> next cycle out_valid=0, occupancy=0, out_data=RESET_DATA; 0xE is never output.
4. Stall: stall_en=1 for 3 cycles in state ONE with out_ready=1 and in_valid=1 -> in_ready=0, out_data frozen, occupancy=1. Release -> flow resumes with no lost beat.
5. Reset: assert ARESET asynchronously between edges while in TWO -> outputs zero immediately; in_ready=1 on the first edge after release.
6. PIPE_TRACE_EN defined: tag each beat with trace=index -> out_trace matches out_data for every beat under the scenario 2 pattern.
